// File: rtl/packet_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : packet_tx_serializer
//  Purpose  : Frames a parallel payload between a start byte and an end byte
//             and shifts it out MSB-first, holding every bit for CLKS_PER_BIT
//             clocks, then enforces a guard interval before the next frame.
//  Revision : 1.0 - initial release
// ============================================================================
module packet_tx_serializer #(
  parameter int         PAYLOAD_BYTES = 6,
  parameter logic [7:0] START_BYTE    = 8'hA5,
  parameter logic [7:0] END_BYTE      = 8'h5A,
  parameter int         CLKS_PER_BIT  = 16,
  parameter int         GUARD_CLKS    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PAYLOAD_BYTES-1:0][7:0] payload,
  input  logic                          send,
  output logic                          tx_bit,
  output logic                          tx_active,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  // --------------------------------------------------------------------------
  // Derived sizes and terminal counter values
  // --------------------------------------------------------------------------
  localparam int C_FRAME_BYTES = PAYLOAD_BYTES + 2;
  localparam int C_FRAME_BITS  = 8 * C_FRAME_BYTES;
  localparam int C_CLK_W       = $clog2(CLKS_PER_BIT);
  localparam int C_BIT_W       = $clog2(C_FRAME_BITS);
  localparam int C_GUARD_W     = $clog2(GUARD_CLKS) + 1;

  localparam logic [C_CLK_W-1:0]   C_CLK_LAST   = C_CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [C_BIT_W-1:0]   C_BIT_LAST   = C_BIT_W'(C_FRAME_BITS - 1);
  localparam logic [C_GUARD_W-1:0] C_GUARD_LAST = C_GUARD_W'(GUARD_CLKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TX    = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t                    r_state;
  logic [C_CLK_W-1:0]        r_clk_cnt;
  logic [C_BIT_W-1:0]        r_bit_idx;
  logic [C_GUARD_W-1:0]      r_guard_cnt;
  logic [C_FRAME_BITS-1:0]   r_shreg;

  state_t                    w_state_n;
  logic [C_CLK_W-1:0]        w_clk_cnt_n;
  logic [C_BIT_W-1:0]        w_bit_idx_n;
  logic [C_GUARD_W-1:0]      w_guard_cnt_n;
  logic [C_FRAME_BITS-1:0]   w_shreg_n;
  logic                      w_done_n;
  logic                      w_overrun_n;
  logic                      w_tx_bit_n;
  logic                      w_tx_active_n;
  logic                      w_busy_n;

  // Frame image: start byte in the top byte, payload[0] next, end byte last,
  // so a plain left shift presents the bits in transmission order.
  logic [C_FRAME_BITS-1:0]   w_frame;

  assign w_frame[C_FRAME_BITS-1 -: 8] = START_BYTE;
  assign w_frame[7:0]                 = END_BYTE;

  generate
    for (genvar g = 0; g < PAYLOAD_BYTES; g++) begin : g_frame_payload
      assign w_frame[8*(PAYLOAD_BYTES-g) +: 8] = payload[g];
    end
  endgenerate

  // Next-state, counter and output-value decode for the framing FSM.
  always_comb begin
    w_state_n     = r_state;
    w_clk_cnt_n   = r_clk_cnt;
    w_bit_idx_n   = r_bit_idx;
    w_guard_cnt_n = r_guard_cnt;
    w_shreg_n     = r_shreg;
    w_done_n      = 1'b0;
    w_overrun_n   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (send) begin
          w_state_n     = S_TX;
          w_shreg_n     = w_frame;
          w_clk_cnt_n   = '0;
          w_bit_idx_n   = '0;
          w_guard_cnt_n = '0;
        end
      end

      S_TX: begin
        w_overrun_n = send;
        if (r_clk_cnt == C_CLK_LAST) begin
          w_clk_cnt_n = '0;
          if (r_bit_idx == C_BIT_LAST) begin
            // The done cycle is counted as the first guard cycle.
            w_state_n     = S_GUARD;
            w_done_n      = 1'b1;
            w_guard_cnt_n = C_GUARD_W'(1);
          end else begin
            w_bit_idx_n = r_bit_idx + C_BIT_W'(1);
            w_shreg_n   = {r_shreg[C_FRAME_BITS-2:0], 1'b0};
          end
        end else begin
          w_clk_cnt_n = r_clk_cnt + C_CLK_W'(1);
        end
      end

      S_GUARD: begin
        w_overrun_n = send;
        if (r_guard_cnt == C_GUARD_LAST) begin
          w_state_n     = S_IDLE;
          w_guard_cnt_n = '0;
        end else begin
          w_guard_cnt_n = r_guard_cnt + C_GUARD_W'(1);
        end
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the flops present them in
    // the same cycle the state they describe becomes current.
    w_tx_active_n = (w_state_n == S_TX);
    w_tx_bit_n    = w_tx_active_n & w_shreg_n[C_FRAME_BITS-1];
    w_busy_n      = (w_state_n != S_IDLE);
  end

  // State, counters, shift register and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_guard_cnt <= '0;
      r_shreg     <= '0;
      tx_bit      <= 1'b0;
      tx_active   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_clk_cnt   <= w_clk_cnt_n;
      r_bit_idx   <= w_bit_idx_n;
      r_guard_cnt <= w_guard_cnt_n;
      r_shreg     <= w_shreg_n;
      tx_bit      <= w_tx_bit_n;
      tx_active   <= w_tx_active_n;
      busy        <= w_busy_n;
      done        <= w_done_n;
      overrun     <= w_overrun_n;
    end
  end

endmodule
`default_nettype wire
